// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: edge-latched pending bits, mask/global
// enable, fixed priority (lowest index first) and single-level in-service tracking.
module interrupt_controller #(
  parameter int              BITS       = 32,
  parameter logic [BITS-1:0] BASE       = 32'hF0000100,
  parameter logic [BITS-1:0] MASK_BASE  = 32'hF0000104,
  parameter logic [BITS-1:0] CAUSE_BASE = 32'hF0000108,
  parameter int              NUM_SRC    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [BITS-1:0]    memAddr,
  input  logic [BITS-1:0]    dataBusIn,
  output logic [BITS-1:0]    dataBusOut,
  input  logic [NUM_SRC-1:0] irqIn,
  input  logic               intAck,
  output logic               intReq,
  output logic [3:0]         intId
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] pend, mask, irqPrev;
  logic [NUM_SRC-1:0] rise, eligible, curBit, pendClr, pendNext;
  logic               gie, inSvc;
  logic [3:0]         svcId, curId, topId;
  logic               pendWr, maskWr, eoiWr;
  logic               unusedBits;

  assign pendWr = we && (memAddr == BASE);
  assign maskWr = we && (memAddr == MASK_BASE);
  assign eoiWr  = we && (memAddr == CAUSE_BASE);

  assign rise     = irqIn & ~irqPrev;
  assign eligible = gie ? (pend & mask) : '0;
  assign curBit   = NUM_SRC'(1) << curId;
  assign pendClr  = (pendWr ? dataBusIn[NUM_SRC-1:0] : '0)
                  | ((state == REQ && intAck) ? curBit : '0);

  // A rising edge always wins over a same-cycle clear.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : gPend
      assign pendNext[gi] = rise[gi] | (pend[gi] & ~pendClr[gi]);
    end
  endgenerate

  always_comb begin
    topId = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) topId = 4'(i);
    end
  end

  always_comb begin
    dataBusOut = '0;
    if (!we) begin
      if (memAddr == BASE) begin
        dataBusOut[NUM_SRC-1:0] = pend;
      end else if (memAddr == MASK_BASE) begin
        dataBusOut[BITS-1]      = gie;
        dataBusOut[NUM_SRC-1:0] = mask;
      end else if (memAddr == CAUSE_BASE) begin
        dataBusOut[BITS-1] = inSvc;
        dataBusOut[3:0]    = svcId;
      end
    end
  end

  // Only a subset of the write data bits is meaningful to this block.
  assign unusedBits = ^dataBusIn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pend    <= '0;
      mask    <= '0;
      gie     <= 1'b0;
      irqPrev <= '0;
      inSvc   <= 1'b0;
      svcId   <= '0;
      curId   <= '0;
      intReq  <= 1'b0;
      intId   <= '0;
    end else begin
      irqPrev <= irqIn;
      pend    <= pendNext;
      if (maskWr) begin
        mask <= dataBusIn[NUM_SRC-1:0];
        gie  <= dataBusIn[BITS-1];
      end
      case (state)
        IDLE: begin
          if (|eligible) begin
            curId  <= topId;
            intId  <= topId;
            intReq <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (intAck) begin
            svcId  <= curId;
            inSvc  <= 1'b1;
            intReq <= 1'b0;
            intId  <= curId;
            state  <= SERVICE;
          end else if (!(|(eligible & curBit))) begin
            intReq <= 1'b0;
            intId  <= '0;
            state  <= IDLE;
          end
        end
        SERVICE: begin
          if (eoiWr) begin
            inSvc <= 1'b0;
            intId <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: each task drives one scenario and
// checks bus reads and the request outputs against hand-computed values.
module tb_interrupt_controller;

  localparam logic [31:0] PEND_A  = 32'hF0000100;
  localparam logic [31:0] MASK_A  = 32'hF0000104;
  localparam logic [31:0] CAUSE_A = 32'hF0000108;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [31:0] memAddr = '0;
  logic [31:0] dataBusIn = '0;
  logic [31:0] dataBusOut;
  logic [3:0]  irqIn = '0;
  logic        intAck = 1'b0;
  logic        intReq;
  logic [3:0]  intId;

  int assertions = 0;
  int failures = 0;

  interrupt_controller dut (
    .clk(clk), .reset(reset), .we(we), .memAddr(memAddr), .dataBusIn(dataBusIn),
    .dataBusOut(dataBusOut), .irqIn(irqIn), .intAck(intAck), .intReq(intReq), .intId(intId)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1; memAddr = addr; dataBusIn = data;
    tick();
    $display("write addr=%h data=%h", addr, data);
    we = 1'b0; memAddr = '0; dataBusIn = '0;
  endtask

  task automatic ack;
    intAck = 1'b1;
    tick();
    $display("ack intId=%0d", intId);
    intAck = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; irqIn = '0;
    tick();
    assertions++; if (intReq !== 1'b0) begin failures++; $display("FAIL rst_req: intReq=%b expected 0", intReq); end
    assertions++; if (intId !== 4'd0) begin failures++; $display("FAIL rst_id: intId=%0d expected 0", intId); end
    reset = 1'b1;
    memAddr = PEND_A; #1;
    assertions++; if (dataBusOut !== 32'h0) begin failures++; $display("FAIL rst_pend: got %h expected 0", dataBusOut); end
    memAddr = 32'h0; #1;
    assertions++; if (dataBusOut !== 32'h0) begin failures++; $display("FAIL rst_noaddr: got %h expected 0", dataBusOut); end
  endtask

  task automatic test_single;
    busWrite(MASK_A, 32'h8000000F);
    memAddr = MASK_A; #1;
    assertions++; if (dataBusOut !== 32'h8000000F) begin failures++; $display("FAIL mask_rd: got %h expected 8000000f", dataBusOut); end
    irqIn = 4'b0001;
    tick();
    irqIn = 4'b0000;
    memAddr = PEND_A; #1;
    assertions++; if (dataBusOut !== 32'h1) begin failures++; $display("FAIL single_pend: got %h expected 1", dataBusOut); end
    assertions++; if (intReq !== 1'b0) begin failures++; $display("FAIL single_early: intReq=%b expected 0", intReq); end
    tick();
    assertions++; if (intReq !== 1'b1 || intId !== 4'd0) begin failures++; $display("FAIL single_req: intReq=%b intId=%0d expected 1/0", intReq, intId); end
    ack();
    memAddr = CAUSE_A; #1;
    assertions++; if (dataBusOut !== 32'h80000000) begin failures++; $display("FAIL single_cause: got %h expected 80000000", dataBusOut); end
    busWrite(CAUSE_A, 32'h0);
    memAddr = CAUSE_A; #1;
    assertions++; if (dataBusOut !== 32'h0 || intReq !== 1'b0 || intId !== 4'd0) begin failures++; $display("FAIL single_eoi: cause=%h intReq=%b intId=%0d expected 0/0/0", dataBusOut, intReq, intId); end
  endtask

  task automatic test_priority;
    irqIn = 4'b0110;
    tick();
    irqIn = 4'b0000;
    tick();
    assertions++; if (intReq !== 1'b1 || intId !== 4'd1) begin failures++; $display("FAIL prio_req: intReq=%b intId=%0d expected 1/1", intReq, intId); end
    ack();
    memAddr = CAUSE_A; #1;
    assertions++; if (dataBusOut !== 32'h80000001) begin failures++; $display("FAIL prio_cause: got %h expected 80000001", dataBusOut); end
    memAddr = PEND_A; #1;
    assertions++; if (dataBusOut !== 32'h4) begin failures++; $display("FAIL prio_pend: got %h expected 4", dataBusOut); end
    assertions++; if (intReq !== 1'b0 || intId !== 4'd1) begin failures++; $display("FAIL prio_svc: intReq=%b intId=%0d expected 0/1", intReq, intId); end
    busWrite(CAUSE_A, 32'h1234);
    assertions++; if (intReq !== 1'b0) begin failures++; $display("FAIL prio_idle: intReq=%b expected 0", intReq); end
    tick();
    assertions++; if (intReq !== 1'b1 || intId !== 4'd2) begin failures++; $display("FAIL prio_next: intReq=%b intId=%0d expected 1/2", intReq, intId); end
    ack();
    busWrite(CAUSE_A, 32'h0);
  endtask

  task automatic test_withdraw;
    irqIn = 4'b1000;
    tick();
    irqIn = 4'b0000;
    tick();
    assertions++; if (intReq !== 1'b1 || intId !== 4'd3) begin failures++; $display("FAIL wd_req: intReq=%b intId=%0d expected 1/3", intReq, intId); end
    busWrite(MASK_A, 32'h80000007);
    tick();
    assertions++; if (intReq !== 1'b0 || intId !== 4'd0) begin failures++; $display("FAIL wd_drop: intReq=%b intId=%0d expected 0/0", intReq, intId); end
    memAddr = PEND_A; #1;
    assertions++; if (dataBusOut !== 32'h8) begin failures++; $display("FAIL wd_pend: got %h expected 8", dataBusOut); end
    busWrite(32'hF000010C, 32'hFFFFFFFF);
    memAddr = PEND_A; #1;
    assertions++; if (dataBusOut !== 32'h8) begin failures++; $display("FAIL wd_badaddr: got %h expected 8", dataBusOut); end
    busWrite(PEND_A, 32'h8);
    memAddr = PEND_A; #1;
    assertions++; if (dataBusOut !== 32'h0) begin failures++; $display("FAIL wd_w1c: got %h expected 0", dataBusOut); end
  endtask

  task automatic test_gie;
    busWrite(MASK_A, 32'h0000000F);
    irqIn = 4'b0101;
    tick();
    irqIn = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      assertions++; if (intReq !== 1'b0) begin failures++; $display("FAIL gie_off%0d: intReq=%b expected 0", i, intReq); end
    end
    memAddr = PEND_A; #1;
    assertions++; if (dataBusOut !== 32'h5) begin failures++; $display("FAIL gie_pend: got %h expected 5", dataBusOut); end
    busWrite(MASK_A, 32'h8000000F);
    tick();
    assertions++; if (intReq !== 1'b1 || intId !== 4'd0) begin failures++; $display("FAIL gie_on: intReq=%b intId=%0d expected 1/0", intReq, intId); end
    ack();
    busWrite(CAUSE_A, 32'h0);
    tick();
    assertions++; if (intReq !== 1'b1 || intId !== 4'd2) begin failures++; $display("FAIL gie_next: intReq=%b intId=%0d expected 1/2", intReq, intId); end
    ack();
    busWrite(CAUSE_A, 32'h0);
  endtask

  task automatic test_service_rise;
    irqIn = 4'b0001;
    tick();
    irqIn = 4'b0000;
    tick();
    ack();
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
    assertions++; if (intReq !== 1'b0 || intId !== 4'd0) begin failures++; $display("FAIL svc_ackign: intReq=%b intId=%0d expected 0/0", intReq, intId); end
    irqIn = 4'b0001;
    tick();
    irqIn = 4'b0000;
    tick();
    memAddr = PEND_A; #1;
    assertions++; if (dataBusOut !== 32'h1 || intReq !== 1'b0) begin failures++; $display("FAIL svc_accum: pend=%h intReq=%b expected 1/0", dataBusOut, intReq); end
    busWrite(CAUSE_A, 32'h0);
    tick();
    assertions++; if (intReq !== 1'b1 || intId !== 4'd0) begin failures++; $display("FAIL svc_rereq: intReq=%b intId=%0d expected 1/0", intReq, intId); end
    // Rise on the source during its own ack cycle must stay pending.
    irqIn = 4'b0001;
    ack();
    irqIn = 4'b0000;
    memAddr = PEND_A; #1;
    assertions++; if (dataBusOut !== 32'h1) begin failures++; $display("FAIL ack_rise: pend=%h expected 1", dataBusOut); end
    busWrite(CAUSE_A, 32'h0);
    tick();
    assertions++; if (intReq !== 1'b1 || intId !== 4'd0) begin failures++; $display("FAIL ack_rise_req: intReq=%b intId=%0d expected 1/0", intReq, intId); end
    ack();
    irqIn = 4'b0010;
    busWrite(CAUSE_A, 32'h0);
    irqIn = 4'b0000;
    assertions++; if (intReq !== 1'b0) begin failures++; $display("FAIL eoi_rise_idle: intReq=%b expected 0", intReq); end
    tick();
    assertions++; if (intReq !== 1'b1 || intId !== 4'd1) begin failures++; $display("FAIL eoi_rise_req: intReq=%b intId=%0d expected 1/1", intReq, intId); end
  endtask

  task automatic test_reset_mid;
    ack();
    irqIn = 4'b0100;
    tick();
    reset = 1'b0;
    #1;
    assertions++; if (intReq !== 1'b0 || intId !== 4'd0) begin failures++; $display("FAIL mid_rst: intReq=%b intId=%0d expected 0/0", intReq, intId); end
    tick();
    reset = 1'b1;
    memAddr = PEND_A; #1;
    assertions++; if (dataBusOut !== 32'h0) begin failures++; $display("FAIL mid_pend: got %h expected 0", dataBusOut); end
    memAddr = MASK_A; #1;
    assertions++; if (dataBusOut !== 32'h0) begin failures++; $display("FAIL mid_mask: got %h expected 0", dataBusOut); end
    memAddr = CAUSE_A; #1;
    assertions++; if (dataBusOut !== 32'h0) begin failures++; $display("FAIL mid_cause: got %h expected 0", dataBusOut); end
    tick();
    memAddr = PEND_A; #1;
    assertions++; if (dataBusOut !== 32'h4) begin failures++; $display("FAIL mid_repend: got %h expected 4", dataBusOut); end
    tick();
    assertions++; if (intReq !== 1'b0) begin failures++; $display("FAIL mid_masked: intReq=%b expected 0", intReq); end
    irqIn = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_withdraw();
    test_gie();
    test_service_rise();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Memory-mapped interrupt controller that sits directly downstream of the timer and the other I/O devices.
- Collects their per-device interrupt lines (e.g. timer ready AND IE), latches them as pending, and applies a mask and a global enable.
- Presents one prioritised interrupt request with its source ID to the pipeline and tracks the in-service source until software writes end-of-interrupt (EOI).
- Shares the same address/data bus as the timer and the other devices.

Parameters:
BITS, 32, bus and register width
BASE, 32'hF0000100, address of PEND register
MASK_BASE, 32'hF0000104, address of MASK register
CAUSE_BASE, 32'hF0000108, address of CAUSE/EOI register
NUM_SRC, 4, number of interrupt sources (1..16, at most BITS-1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
we  input  1  1 = bus write cycle, 0 = bus read cycle
memAddr  input  BITS  bus address
dataBusIn  input  BITS  write data
dataBusOut  output  BITS  read data; 0 when this block is not addressed
irqIn  input  NUM_SRC  level interrupt lines from devices; bit 0 = timer
intAck  input  1  one-cycle pulse from the CPU when it takes the interrupt
intReq  output  1  interrupt request to the CPU
intId  output  4  source ID of the current request or in-service source

Behaviour:
- Reset (reset=0, asynchronous): pend, mask, gie, irqPrev, inSvc, svcId and curId cleared; state=IDLE. Outputs intReq=0, intId=0, dataBusOut=0 (no address match).
- Edge detect: irqPrev<=irqIn every cycle. rise[i]=irqIn[i]&~irqPrev[i]. A line already high when reset releases produces a rise in the first clock.
- pend[i] next value:
  - set if rise[i];
  - else cleared by a PEND write with dataBusIn[i]=1 (write-1-to-clear), or by the intAck cycle for i==curId;
  - else held.
  - Set wins over any clear in the same cycle.
- MASK register: write at MASK_BASE loads mask<=dataBusIn[NUM_SRC-1:0] and gie<=dataBusIn[BITS-1].
- Reads are combinational, with we=0 and an exact address match:
  - PEND reads {0, pend}.
  - MASK reads {gie, 0, mask}.
  - CAUSE reads {inSvc, 0, svcId[3:0]}.
  - Any other address reads 0.
- eligible = pend & mask, qualified by gie. Priority: lowest index wins (timer highest).
- FSM:
  - IDLE: intReq=0. If eligible!=0, latch curId=highest-priority index and go to REQ next cycle, so intReq rises one cycle after pend is set.
  - REQ: intReq=1, intId=curId, frozen. If intAck=1: clear pend[curId], svcId<=curId, inSvc<=1, go to SERVICE. Else if eligible[curId]==0 (cleared, masked or gie dropped): go to IDLE (request withdrawn, no ack).
  - SERVICE: intReq=0, intId=svcId, no nesting. A write of any value to CAUSE_BASE (EOI) sets inSvc<=0 and goes to IDLE. New pends accumulate meanwhile and are requested after EOI.
- intAck outside REQ is ignored. An EOI write outside SERVICE is ignored.
- Writes are ignored at all addresses except BASE, MASK_BASE and CAUSE_BASE.
- intId=0 in IDLE.
- Same-cycle events:
  - A rise on a source during its own ack cycle leaves it pending and requests again after EOI.
  - An EOI write in the same cycle as a new rise goes to IDLE, then REQ next cycle.
- Reset asserted in any state returns immediately to reset values; pending interrupts are lost.

Test Plan:
- Reset, then mask=4'hF and gie=1 (write 32'h8000000F to MASK). Pulse irqIn[0] high -> pend=1 next cycle; intReq=1, intId=0 one cycle later. Read PEND returns 32'h1.
- irqIn[2] and irqIn[1] rise in the same cycle -> request intId=1. Ack -> CAUSE reads 32'h80000001, PEND reads 32'h4. EOI write -> next request intId=2.
- In REQ for id 3, write MASK=32'h80000007 -> intReq drops next cycle and state is IDLE. pend[3] stays 1; PEND reads 32'h8.
- gie=0 with pend=4'h5 -> intReq stays 0 for 10 cycles. Then set gie=1 -> intReq=1, intId=0.
- In SERVICE (svcId=0), irqIn[0] toggles 0->1 -> pend[0]=1, intReq stays 0. EOI -> IDLE then REQ intId=0.
- Assert reset mid-SERVICE -> intReq=0, intId=0, and PEND, MASK and CAUSE all read 0 after release. A line held high across reset release re-pends in the first cycle.
